// File: rtl/auth_pkg.sv
// Shared definitions for the authenticated message receiver: message codes,
// header layout, per-type word counts and the receive state enumeration.
package auth_pkg;

    localparam int WORD_W    = 64;
    localparam int MAX_WORDS = 7;
    localparam int MSG_W     = WORD_W * MAX_WORDS;

    localparam int DEF_ACCEPTABLE_DELAY = 10;

    localparam logic [7:0] MSG_M1 = 8'd1;
    localparam logic [7:0] MSG_M2 = 8'd2;
    localparam logic [7:0] MSG_M3 = 8'd3;
    localparam logic [7:0] MSG_M4 = 8'd4;

    localparam logic [7:0] WORDS_M1 = 8'd4;
    localparam logic [7:0] WORDS_M2 = 8'd5;
    localparam logic [7:0] WORDS_M3 = 8'd6;
    localparam logic [7:0] WORDS_M4 = 8'd7;

    localparam int HDR_TYPE_HI = 63;
    localparam int HDR_TYPE_LO = 56;
    localparam int HDR_NW_HI   = 55;
    localparam int HDR_NW_LO   = 48;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DRAIN,
        HOLD
    } state_t;

    // Zero marks an unknown message type.
    function automatic logic [7:0] words_for_type(input logic [7:0] msg_type);
        case (msg_type)
            MSG_M1:  return WORDS_M1;
            MSG_M2:  return WORDS_M2;
            MSG_M3:  return WORDS_M3;
            MSG_M4:  return WORDS_M4;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/auth_ts_check.sv
// Free-running local timestamp plus the freshness comparator; shared between
// the receive and transmit sides.
module auth_ts_check #(
    parameter int TS_W             = 48,
    parameter int ACCEPTABLE_DELAY = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [TS_W-1:0] hdr_ts,
    output logic [TS_W-1:0] now_ts,
    output logic            fresh
);

    localparam logic [TS_W-1:0] DELAY_LIM = TS_W'(ACCEPTABLE_DELAY);
    localparam logic [TS_W-1:0] TS_ONE    = TS_W'(1);

    logic [TS_W-1:0] now_ts_reg;
    logic [TS_W-1:0] delta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            now_ts_reg <= '0;
        end else begin
            now_ts_reg <= now_ts_reg + TS_ONE;
        end
    end

    // Modular difference: a timestamp from the future wraps to a huge age.
    assign delta  = now_ts_reg - hdr_ts;
    assign fresh  = (delta <= DELAY_LIM);
    assign now_ts = now_ts_reg;

endmodule

// File: rtl/auth_msg_rx.sv
// Receives header + payload frames, checks framing and freshness, XOR-decrypts
// the payload with the key latched at the header and holds the message.
module auth_msg_rx
    import auth_pkg::*;
#(
    parameter int ACCEPTABLE_DELAY = DEF_ACCEPTABLE_DELAY,
    parameter int TS_W             = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_last,
    input  logic [63:0]      key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MSG_W-1:0] out_msg,
    output logic [3:0]       out_type,
    output logic [2:0]       out_nwords,
    output logic             err_stale,
    output logic             err_format,
    output logic [15:0]      drop_cnt,
    output logic [TS_W-1:0]  now_ts
);

    state_t            state_reg, state_next;
    logic [63:0]       key_reg, key_next;
    logic [MSG_W-1:0]  msg_reg, msg_next;
    logic [3:0]        type_reg, type_next;
    logic [2:0]        nwords_reg, nwords_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic              err_stale_reg, err_stale_next;
    logic              err_format_reg, err_format_next;
    logic [15:0]       drop_cnt_reg, drop_cnt_next;

    logic [7:0]        hdr_type;
    logic [7:0]        hdr_nwords;
    logic [7:0]        hdr_expect;
    logic              hdr_ok;
    logic              fresh;
    logic              accept;
    logic [2:0]        word_num;

    auth_ts_check #(
        .TS_W             (TS_W),
        .ACCEPTABLE_DELAY (ACCEPTABLE_DELAY)
    ) u_ts_check (
        .clk    (clk),
        .rst    (rst),
        .hdr_ts (in_data[TS_W-1:0]),
        .now_ts (now_ts),
        .fresh  (fresh)
    );

    assign hdr_type   = in_data[HDR_TYPE_HI:HDR_TYPE_LO];
    assign hdr_nwords = in_data[HDR_NW_HI:HDR_NW_LO];
    assign hdr_expect = words_for_type(hdr_type);
    assign hdr_ok     = (hdr_expect != 8'd0) && (hdr_nwords == hdr_expect);
    assign word_num   = cnt_reg + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            key_reg        <= '0;
            msg_reg        <= '0;
            type_reg       <= '0;
            nwords_reg     <= '0;
            cnt_reg        <= '0;
            err_stale_reg  <= 1'b0;
            err_format_reg <= 1'b0;
            drop_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            key_reg        <= key_next;
            msg_reg        <= msg_next;
            type_reg       <= type_next;
            nwords_reg     <= nwords_next;
            cnt_reg        <= cnt_next;
            err_stale_reg  <= err_stale_next;
            err_format_reg <= err_format_next;
            drop_cnt_reg   <= drop_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        key_next        = key_reg;
        msg_next        = msg_reg;
        type_next       = type_reg;
        nwords_next     = nwords_reg;
        cnt_next        = cnt_reg;
        err_stale_next  = 1'b0;
        err_format_next = 1'b0;
        in_ready        = (state_reg != HOLD);
        out_valid       = (state_reg == HOLD);
        accept          = in_valid && in_ready;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    key_next = key;
                    // Format problems outrank staleness so only one pulse fires.
                    if (!hdr_ok || in_last) begin
                        err_format_next = 1'b1;
                        state_next      = in_last ? IDLE : DRAIN;
                    end else if (!fresh) begin
                        err_stale_next = 1'b1;
                        state_next     = DRAIN;
                    end else begin
                        state_next  = PAYLOAD;
                        type_next   = hdr_type[3:0];
                        nwords_next = hdr_nwords[2:0];
                        msg_next    = '0;
                        cnt_next    = '0;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    msg_next = {msg_reg[MSG_W-WORD_W-1:0], in_data ^ key_reg};
                    cnt_next = word_num;
                    if (word_num == nwords_reg) begin
                        if (in_last) begin
                            state_next = HOLD;
                        end else begin
                            err_format_next = 1'b1;
                            state_next      = DRAIN;
                        end
                    end else if (in_last) begin
                        err_format_next = 1'b1;
                        state_next      = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (accept && in_last) begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if ((err_stale_next || err_format_next) && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_next = drop_cnt_reg + 16'd1;
        end
    end

    assign out_msg    = msg_reg;
    assign out_type   = type_reg;
    assign out_nwords = nwords_reg;
    assign err_stale  = err_stale_reg;
    assign err_format = err_format_reg;
    assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_auth_msg_rx.sv
// Directed plus randomized frames against a frame-level reference model of the
// receiver, compared on every falling clock edge.
module tb_auth_msg_rx;

    localparam int TS_W  = 48;
    localparam int DELAY = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [63:0]    in_data = '0;
    logic           in_last = 1'b0;
    logic [63:0]    key = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [447:0]   out_msg;
    logic [3:0]     out_type;
    logic [2:0]     out_nwords;
    logic           err_stale;
    logic           err_format;
    logic [15:0]    drop_cnt;
    logic [TS_W-1:0] now_ts;

    always #5 clk = ~clk;

    auth_msg_rx #(.ACCEPTABLE_DELAY(DELAY), .TS_W(TS_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_msg    (out_msg),
        .out_type   (out_type),
        .out_nwords (out_nwords),
        .err_stale  (err_stale),
        .err_format (err_format),
        .drop_cnt   (drop_cnt),
        .now_ts     (now_ts)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 awaiting header, 1 collecting, 2 discarding, 3 holding.
    int          m_phase;
    logic [47:0] m_ts;
    logic [63:0] m_key;
    logic [7:0]  m_type;
    logic [7:0]  m_nw;
    logic [63:0] m_q[$];
    bit          m_stale;
    bit          m_fmt;
    int          m_drop;
    bit          rand_en = 1'b0;

    task automatic chk(input string name, input logic [447:0] act, input logic [447:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ts    = '0;
        m_key   = '0;
        m_type  = '0;
        m_nw    = '0;
        m_q.delete();
        m_stale = 1'b0;
        m_fmt   = 1'b0;
        m_drop  = 0;
    endtask

    function automatic logic [447:0] model_msg();
        logic [447:0] m;
        m = '0;
        foreach (m_q[i]) m = {m[383:0], m_q[i]};
        return m;
    endfunction

    task automatic model_step();
        logic [7:0]  t, n;
        logic [47:0] ts, age;
        m_stale = 1'b0;
        m_fmt   = 1'b0;
        case (m_phase)
            0: if (in_valid) begin
                t = in_data[63:56];
                n = in_data[55:48];
                ts = in_data[47:0];
                age = m_ts - ts;
                m_key = key;
                if (t < 1 || t > 4 || n != t + 8'd3 || in_last) m_fmt = 1'b1;
                else if (age > 48'(DELAY)) m_stale = 1'b1;
                else begin
                    m_phase = 1;
                    m_type  = t;
                    m_nw    = n;
                    m_q.delete();
                end
                if (m_fmt || m_stale) m_phase = in_last ? 0 : 2;
            end
            1: if (in_valid) begin
                m_q.push_back(in_data ^ m_key);
                if (m_q.size() == int'(m_nw)) begin
                    if (in_last) m_phase = 3;
                    else begin m_fmt = 1'b1; m_phase = 2; end
                end else if (in_last) begin
                    m_fmt = 1'b1;
                    m_phase = 0;
                end
            end
            2: if (in_valid && in_last) m_phase = 0;
            3: if (out_ready) m_phase = 0;
            default: m_phase = 0;
        endcase
        if ((m_fmt || m_stale) && m_drop < 65535) m_drop++;
        m_ts = m_ts + 48'd1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            chk("now_ts", now_ts, m_ts);
            chk("in_ready", in_ready, m_phase != 3);
            chk("out_valid", out_valid, m_phase == 3);
            chk("err_stale", err_stale, m_stale);
            chk("err_format", err_format, m_fmt);
            chk("drop_cnt", drop_cnt, 16'(m_drop));
            if (m_phase == 3) begin
                chk("out_msg", out_msg, model_msg());
                chk("out_type", out_type, m_type[3:0]);
                chk("out_nwords", out_nwords, m_nw[2:0]);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_en) begin
                out_ready = ($urandom_range(0, 2) != 0);
                key = {$urandom, $urandom};
            end
        end
    end

    function automatic logic [63:0] hdr(input logic [7:0] t, input logic [7:0] n, input logic [47:0] ts);
        return {t, n, ts};
    endfunction

    task automatic send_word(input logic [63:0] d, input bit last);
        bit acc;
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        do begin
            acc = (m_phase != 3);
            @(posedge clk);
            #2;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=stalled required=accepted");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_ts(input logic [47:0] v);
        int guard;
        guard = 0;
        while (m_ts != v && guard < 5000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (m_ts != v) begin
            checks++;
            failures++;
            $display("FAIL wait_ts actual=%0d required=%0d", m_ts, v);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
    endtask

    logic [63:0]  w[7];
    logic [447:0] exp_msg;
    logic [255:0] e256;

    initial begin
        // Reset values
        #7;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_msg", out_msg, '0);
        chk("rst_out_type", out_type, 4'd0);
        chk("rst_out_nwords", out_nwords, 3'd0);
        chk("rst_drop_cnt", drop_cnt, 16'd0);
        chk("rst_now_ts", now_ts, '0);
        chk("rst_errs", {err_stale, err_format}, 2'b00);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Good M1 frame at now_ts=100
        key = '1;
        wait_ts(48'd100);
        send_word(hdr(8'd1, 8'd4, 48'd95), 1'b0);
        for (int i = 0; i < 4; i++) send_word(64'h1111_1111_1111_1111, i == 3);
        e256 = {4{64'hEEEE_EEEE_EEEE_EEEE}};
        chk("m1_out_valid", out_valid, 1'b1);
        chk("m1_low", out_msg[255:0], e256);
        chk("m1_high", out_msg[447:256], '0);
        chk("m1_type", out_type, 4'd1);
        release_out();
        chk("m1_done", out_valid, 1'b0);

        // Freshness boundary: age 10 accepted, age 11 stale
        wait_ts(48'd200);
        send_word(hdr(8'd1, 8'd4, 48'd190), 1'b0);
        for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, i == 3);
        chk("edge_accept", out_valid, 1'b1);
        release_out();
        wait_ts(48'd300);
        send_word(hdr(8'd1, 8'd4, 48'd289), 1'b0);
        chk("stale_pulse", {err_stale, err_format}, 2'b10);
        for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, i == 3);
        chk("stale_no_out", out_valid, 1'b0);
        chk("stale_drop", drop_cnt, 16'd1);

        // Early in_last, then back-to-back header
        send_word(hdr(8'd2, 8'd5, m_ts), 1'b0);
        for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, i == 2);
        chk("early_last", {err_stale, err_format}, 2'b01);
        chk("early_ready", in_ready, 1'b1);
        send_word(hdr(8'd1, 8'd4, m_ts), 1'b0);
        chk("next_hdr_ok", err_format, 1'b0);
        for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, i == 3);
        chk("next_frame_out", out_valid, 1'b1);
        release_out();
        // Type/length mismatch
        send_word(hdr(8'd3, 8'd5, m_ts), 1'b0);
        chk("bad_len", {err_stale, err_format}, 2'b01);
        for (int i = 0; i < 5; i++) send_word({$urandom, $urandom}, i == 4);
        chk("fmt_drop", drop_cnt, 16'd3);

        // Backpressure on an M2 frame
        key = 64'h0123_4567_89AB_CDEF;
        exp_msg = '0;
        send_word(hdr(8'd2, 8'd5, m_ts - 48'd2), 1'b0);
        key = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            w[i] = {$urandom, $urandom};
            exp_msg = {exp_msg[383:0], w[i] ^ 64'h0123_4567_89AB_CDEF};
            send_word(w[i], i == 4);
        end
        for (int c = 0; c < 3; c++) begin
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_msg", out_msg, exp_msg);
            @(posedge clk);
            #2;
        end
        release_out();
        chk("bp_done_valid", out_valid, 1'b0);
        chk("bp_done_ready", in_ready, 1'b1);

        // Reset part way through an M3 frame
        send_word(hdr(8'd3, 8'd6, m_ts), 1'b0);
        for (int i = 0; i < 2; i++) send_word({$urandom, $urandom}, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_ts", now_ts, '0);
        chk("mid_rst_drop", drop_cnt, 16'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        wait_ts(48'd5);
        key = 64'h5A5A_0F0F_A5A5_F0F0;
        exp_msg = '0;
        send_word(hdr(8'd1, 8'd4, 48'd2), 1'b0);
        for (int i = 0; i < 4; i++) begin
            w[i] = {$urandom, $urandom};
            exp_msg = {exp_msg[383:0], w[i] ^ 64'h5A5A_0F0F_A5A5_F0F0};
            send_word(w[i], i == 3);
        end
        chk("post_rst_msg", out_msg, exp_msg);
        chk("post_rst_err", {err_stale, err_format}, 2'b00);
        release_out();

        // Timestamp from the future
        wait_ts(48'd50);
        send_word(hdr(8'd1, 8'd4, 48'd51), 1'b0);
        chk("future_stale", {err_stale, err_format}, 2'b10);
        for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, i == 3);
        chk("future_drop", drop_cnt, 16'd1);

        // Randomized frames
        rand_en = 1'b1;
        for (int f = 0; f < 150; f++) begin
            logic [7:0]  t, n;
            logic [47:0] ts;
            int          len;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #2;
            end
            t = 8'($urandom_range(0, 5));
            n = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 8)) : t + 8'd3;
            if ($urandom_range(0, 9) == 0) ts = m_ts + 48'($urandom_range(1, 5));
            else ts = m_ts - 48'($urandom_range(0, 13));
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8)) : int'(n);
            send_word(hdr(t, n, ts), len == 0);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    @(posedge clk);
                    #2;
                end
                send_word({$urandom, $urandom}, i == len - 1);
            end
        end
        rand_en = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/auth_msg_rx.md
AUTH_MSG_RX -- requirements
Module: auth_msg_rx

Interface
REQ-001 The block SHALL have parameter ACCEPTABLE_DELAY, default 10, meaning the maximum allowed age of a message timestamp in cycles.
REQ-002 The block SHALL have parameter TS_W, default 48, meaning the timestamp width.
REQ-003 The block SHALL use clock clk; reset rst, asynchronous, active-high.
REQ-004 The block SHALL provide the following ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- in_valid  in  1  inbound word valid
- in_ready  out  1  inbound word accepted when both valid and ready are high
- in_data  in  64  inbound word
- in_last  in  1  final word of a frame
- key  in  64  XOR session key, sampled at header acceptance
- out_valid  out  1  decrypted message available
- out_ready  in  1  consumer accepts the message
- out_msg  out  448  decrypted payload, right-aligned; first payload word most significant
- out_type  out  4  message type, 1..4 = M1..M4
- out_nwords  out  3  payload word count
- err_stale  out  1  one-cycle pulse: freshness failure
- err_format  out  1  one-cycle pulse: framing or type failure
- drop_cnt  out  16  count of dropped frames, saturating
- now_ts  out  TS_W  local timestamp

Function
REQ-005 now_ts SHALL increment by 1 every cycle from 0 after reset and wrap modulo 2^TS_W.
REQ-006 The first word of each frame SHALL be the header, with fields [63:56] type, [55:48] nwords, [TS_W-1:0] sender timestamp.
REQ-007 A header SHALL be valid only if type is 1..4 and nwords equals type+3 (M1=4, M2=5, M3=6, M4=7 words); otherwise the block SHALL pulse err_format.
REQ-008 At header acceptance the block SHALL compute delta = (now_ts - hdr_ts) mod 2^TS_W, and delta > ACCEPTABLE_DELAY SHALL pulse err_stale.
- delta = 10 passes.
- A future timestamp wraps to a large delta and fails.
REQ-009 State machine:
- IDLE: on header accepted, go to PAYLOAD if the header is fresh and valid; go to DRAIN on error when in_last=0; stay in IDLE on error when in_last=1.
- A header carrying in_last=1 SHALL always be a format error.
REQ-010 PAYLOAD: each accepted word SHALL be XORed with the latched key and shifted into the message register.
- in_last on word k < nwords -> err_format, go to IDLE.
- Word nwords without in_last -> err_format, go to DRAIN.
- Word nwords with in_last -> go to HOLD.
REQ-011 DRAIN: words SHALL be accepted and discarded until an accepted word carries in_last, then the block SHALL go to IDLE.
REQ-012 HOLD: out_valid=1, and out_msg, out_type and out_nwords SHALL be stable; out_valid & out_ready SHALL return the block to IDLE.
REQ-013 in_ready SHALL be 1 in IDLE, PAYLOAD and DRAIN, and 0 in HOLD.
REQ-014 out_valid SHALL rise in the cycle after the last payload word is accepted.
REQ-015 Bits of out_msg above nwords*64 SHALL be zero.
REQ-016 Each err_stale or err_format pulse SHALL increment drop_cnt, saturating at 0xFFFF.
REQ-017 err_stale and err_format SHALL never assert in the same cycle; a stale timestamp on an invalid header SHALL report err_format only.
REQ-018 The key SHALL NOT be re-sampled mid-frame; key changes during PAYLOAD SHALL have no effect on the frame in progress.

Reset
REQ-019 Reset SHALL force:
- IDLE state; now_ts=0
- out_valid=0, out_msg=0, out_type=0, out_nwords=0
- err_stale=0, err_format=0, drop_cnt=0
- latched key cleared
REQ-020 Reset during PAYLOAD or HOLD SHALL discard the partial or pending message without producing an output or an error pulse.

Structure
REQ-021 Package auth_pkg SHALL hold:
- MSG_M1..MSG_M4 codes
- words-per-type table
- header field positions
- ACCEPTABLE_DELAY default
- the state enumeration (IDLE, PAYLOAD, DRAIN, HOLD)
REQ-022 The freshness compare and timestamp counter SHALL live in one sub-module, auth_ts_check (counter plus delta comparator), for reuse by the transmit side.

Verification
REQ-023 The bench SHALL cover a good M1 frame: key=all-ones, now_ts=100, header type1/nwords4/ts=95, payload 4x 0x1111111111111111 -> out_valid one cycle after word 4, out_msg[255:0]=4x 0xEEEEEEEEEEEEEEEE, upper bits 0, out_type=1.
REQ-024 The bench SHALL cover the freshness boundary: now_ts=200 with ts=190 -> accepted; ts=189 -> err_stale, 4 words drained, drop_cnt=1, no out_valid.
REQ-025 The bench SHALL cover a future timestamp: now_ts=50, ts=51 -> err_stale and a drain.
REQ-026 The bench SHALL cover framing errors:
- type2/nwords5 with in_last on word 3 -> err_format, IDLE, next header accepted on the following cycle.
- type3/nwords5 -> err_format, drain.
REQ-027 The bench SHALL cover backpressure: out_ready low for 3 cycles in HOLD -> in_ready=0 and out_msg stable; out_ready high -> handshake completes, IDLE next cycle.
REQ-028 The bench SHALL cover reset after 2 of 6 M3 payload words -> out_valid=0, now_ts=0, drop_cnt=0, and a subsequent good frame decodes correctly.
